// File: rtl/fast_pkg.sv
// rtl/fast_pkg.sv - shared types, constants and helpers for the FAST field encoder
package fast_pkg;

  typedef enum logic [1:0] {
    INT   = 2'd0,
    UINT  = 2'd1,
    DECI  = 2'd2,
    ASCII = 2'd3
  } fast_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } enc_state_e;

  localparam logic [7:0] STOP_BIT   = 8'h80;
  localparam int         GROUP_BITS = 7;
  localparam int         MAX_BYTES  = 10;
  localparam int         WORD_BITS  = GROUP_BITS * MAX_BYTES;

  // {valid, msg_id, field_num}, right-aligned; callers cast down to their own tag widths.
  function automatic logic [127:0] pack_err(input logic [63:0] msg_id,
                                            input logic [31:0] field_num,
                                            input int          id_w,
                                            input int          fn_w);
    logic [127:0] w_word;
    w_word = (128'd1 << (id_w + fn_w)) | ({64'd0, msg_id} << fn_w) | {96'd0, field_num};
    return w_word;
  endfunction

endpackage

// File: rtl/fast_stopbit_sizer.sv
// rtl/fast_stopbit_sizer.sv - byte count and stop-bit formatting of a 70-bit extended integer
module fast_stopbit_sizer
  import fast_pkg::*;
(
  input  logic [WORD_BITS-1:0]   i_word,
  input  logic                   i_signed,
  output logic [3:0]             o_n,
  output logic [8*MAX_BYTES-1:0] o_bytes
);

  logic signed [WORD_BITS-1:0] w_sword;
  logic [WORD_BITS-1:0]        w_hi;
  logic [GROUP_BITS-1:0]       w_grp;
  int                          w_len;

  always_comb begin
    w_sword = i_word;
    w_hi    = '0;
    w_grp   = '0;
    w_len   = MAX_BYTES;
    // Descending scan leaves the smallest byte count whose range still holds the word.
    for (int k = MAX_BYTES - 1; k >= 1; k--) begin
      if (i_signed) begin
        w_hi = w_sword >>> (GROUP_BITS * k - 1);
        if (w_hi == '0 || w_hi == '1) w_len = k;
      end else begin
        w_hi = i_word >> (GROUP_BITS * k);
        if (w_hi == '0) w_len = k;
      end
    end
    o_n     = 4'(w_len);
    o_bytes = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < w_len) begin
        w_grp = GROUP_BITS'(i_word >> (GROUP_BITS * (w_len - 1 - i)));
        o_bytes[8*i +: 8] = {(i == w_len - 1), w_grp};
      end
    end
  end

endmodule

// File: rtl/fast_field_encoder.sv
// rtl/fast_field_encoder.sv - FAST stop-bit field encoder packing each field into at most two beats
module fast_field_encoder
  import fast_pkg::*;
#(
  parameter int beat_width       = 64,
  parameter int messageID_size   = 21,
  parameter int max_message_size = 10
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [beat_width-1:0]                       in_value,
  input  logic [1:0]                                  in_type,
  input  logic                                        in_nullable,
  input  logic                                        in_null,
  input  logic [3:0]                                  in_ascii_len,
  input  logic [messageID_size-1:0]                   in_msg_id,
  input  logic [$clog2(max_message_size)-1:0]         in_field_num,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [beat_width-1:0]                       out_data,
  output logic [beat_width/8-1:0]                     out_keep,
  output logic                                        out_complete,
  output logic [messageID_size-1:0]                   out_msg_id,
  output logic [$clog2(max_message_size)-1:0]         out_field_num,
  output logic [messageID_size+$clog2(max_message_size):0] enc_error
);

  localparam int FN_W   = $clog2(max_message_size);
  localparam int ERR_W  = 1 + messageID_size + FN_W;
  localparam int KEEP_W = beat_width / 8;

  enc_state_e                 r_state, w_next;
  logic [beat_width-1:0]      r_data;
  logic [KEEP_W-1:0]          r_keep, r_hi_keep;
  logic                       r_complete;
  logic [15:0]                r_hi;
  logic [messageID_size-1:0]  r_msg_id;
  logic [FN_W-1:0]            r_field_num;
  logic [ERR_W-1:0]           r_err;

  logic                       w_accept, w_hs, w_err, w_bad_char;
  logic [64:0]                w_v65;
  logic [WORD_BITS-1:0]       w_word;
  logic [3:0]                 w_int_n, w_n;
  logic [8*MAX_BYTES-1:0]     w_int_bytes, w_bytes;
  int                         w_alen;

  fast_stopbit_sizer u_sizer (
    .i_word   (w_word),
    .i_signed (in_type == INT),
    .o_n      (w_int_n),
    .o_bytes  (w_int_bytes)
  );

  always_comb begin
    w_alen     = int'(in_ascii_len);
    w_bad_char = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < w_alen && in_value[8*i+7]) w_bad_char = 1'b1;
    end
    w_err = (in_type == DECI) || (in_null && !in_nullable) ||
            (in_type == ASCII && (in_ascii_len > 4'd8 || w_bad_char));

    // 65-bit nullable bump so the maximum values gain a byte instead of wrapping.
    if (in_type == INT) begin
      w_v65  = {in_value[63], in_value[63:0]} + {64'd0, in_nullable && !in_value[63]};
      w_word = {{5{w_v65[64]}}, w_v65};
    end else begin
      w_v65  = {1'b0, in_value[63:0]} + {64'd0, in_nullable};
      w_word = {5'd0, w_v65};
    end

    w_n     = w_int_n;
    w_bytes = w_int_bytes;
    if (in_null || (in_type == ASCII && in_ascii_len == 4'd0)) begin
      w_n     = 4'd1;
      w_bytes = {72'd0, STOP_BIT};
    end else if (in_type == ASCII) begin
      w_n     = in_ascii_len;
      w_bytes = '0;
      for (int i = 0; i < 8; i++) begin
        if (i < w_alen)
          w_bytes[8*i +: 8] = in_value[8*i +: 8] | ((i == w_alen - 1) ? STOP_BIT : 8'h00);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && !w_err) w_next = S_BEAT0;
      S_BEAT0: if (out_ready) begin
                 if (!r_complete)            w_next = S_BEAT1;
                 else if (w_accept && !w_err) w_next = S_BEAT0;
                 else                         w_next = S_IDLE;
               end
      S_BEAT1: if (out_ready) w_next = (w_accept && !w_err) ? S_BEAT0 : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state != S_IDLE);
    w_hs      = out_valid && out_ready;
    in_ready  = !rst && ((r_state == S_IDLE) || (w_hs && r_complete));
    w_accept  = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_keep      <= '0;
      r_complete  <= 1'b0;
      r_hi        <= '0;
      r_hi_keep   <= '0;
      r_msg_id    <= '0;
      r_field_num <= '0;
      r_err       <= '0;
    end else begin
      r_err <= '0;
      if (w_accept && w_err)
        r_err <= ERR_W'(pack_err(64'(in_msg_id), 32'(in_field_num), messageID_size, FN_W));
      if (w_accept && !w_err) begin
        r_data      <= beat_width'(w_bytes[63:0]);
        r_keep      <= (w_n >= 4'd8) ? KEEP_W'(8'hFF) : KEEP_W'((9'd1 << w_n) - 9'd1);
        r_complete  <= (w_n <= 4'd8);
        r_hi        <= w_bytes[79:64];
        r_hi_keep   <= (w_n == 4'd9) ? KEEP_W'(8'h01) : KEEP_W'(8'h03);
        r_msg_id    <= in_msg_id;
        r_field_num <= in_field_num;
      end else if (w_hs && !r_complete) begin
        r_data     <= beat_width'(r_hi);
        r_keep     <= r_hi_keep;
        r_complete <= 1'b1;
      end else if (w_hs) begin
        r_data     <= '0;
        r_keep     <= '0;
        r_complete <= 1'b0;
      end
    end
  end

  assign out_data      = r_data;
  assign out_keep      = r_keep;
  assign out_complete  = r_complete;
  assign out_msg_id    = r_msg_id;
  assign out_field_num = r_field_num;
  assign enc_error     = r_err;

endmodule

// File: doc/fast_field_encoder.md
# fast_field_encoder

- Transmit-side counterpart of the FAST field decoder; sits between the order/quote formatter and the beat-level transmit FIFO.
- Accepts one fully-known field per handshake: value, datatype, nullability, message ID, field number.
- Produces the FAST stop-bit wire encoding of that field, packed into beat_width-bit beats with a byte-keep mask and a field-complete flag.
- The receive path consumes these beats directly.

## Interface
Parameters:
- beat_width, 64, output beat width in bits; only 64 is supported.
- messageID_size, 21, width of the message ID.
- max_message_size, 10, maximum fields per template; field number width is $clog2(max_message_size).

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  field offered.
- in_ready  out  1  field accepted when in_valid && in_ready.
- in_value  in  beat_width  field payload. Integer types are raw 64-bit. For ASCII, char i is in bits [8i+7:8i].
- in_type  in  2  datatype: 0 int64, 1 uint64, 2 decimal (unsupported), 3 ASCII.
- in_nullable  in  1  apply the FAST nullable transform.
- in_null  in  1  encode NULL; valid only with in_nullable.
- in_ascii_len  in  4  ASCII length, 0–8.
- in_msg_id  in  messageID_size  carried to the output.
- in_field_num  in  $clog2(max_message_size)  carried to the output.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  beat_width  encoded bytes; wire byte 0 is in [7:0].
- out_keep  out  beat_width/8  byte-valid mask; always contiguous from lane 0.
- out_complete  out  1  last beat of the field.
- out_msg_id, out_field_num  out  as input  tags of the current beat.
- enc_error  out  1+messageID_size+$clog2(max_message_size)  single-cycle pulse. Layout: {valid, msg_id, field_num}, identical to the decoder error format.

## Operation
Integer encoding:
- The value is split into 7-bit groups and emitted most-significant group first.
- Bit 7 of the final byte is the stop bit (1); bit 7 of every other byte is 0.
- Byte count n:
  - uint: n = max(1, ceil(msb_index+1 / 7)).
  - int: smallest n such that the value fits 7n-bit two's complement.
  - n ranges 1–10.
- Nullable transform:
  - NULL encodes as a single byte 0x80.
  - Otherwise uint becomes v+1.
  - int becomes v+1 when v ≥ 0; negative values are unchanged.
  - The transform is computed in 65-bit arithmetic, so uint max+1 and int max+1 do not wrap.
  - Grouping runs over a 70-bit zero- or sign-extended word.

ASCII encoding:
- Chars are emitted in order; the stop bit is OR'd into the last char.
- len 0 encodes as 0x80; nullable NULL also encodes as 0x80.

Beat packing:
- Bytes 0–7 of the field go in beat 0 and bytes 8–9 in beat 1, so at most 2 beats per field.
- A field never shares a beat with another field.

Errors:
- Triggers: in_type == 2, in_ascii_len > 8, any ASCII char with bit 7 set, or in_null without in_nullable.
- The field is consumed, no beats are emitted, and enc_error pulses.

State machine:
- IDLE: in_ready=1. On accept go to BEAT0, or raise the error pulse and stay in IDLE.
- BEAT0: hold outputs until out_ready. Then go to BEAT1 if n>8, otherwise IDLE. If a new field is accepted in the same cycle, stay in BEAT0 with the new field.
- BEAT1: hold until out_ready, then IDLE. Same-cycle accept is allowed here too.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_complete).

## Timing
- Reset: on the cycle after rst is high, state=IDLE and every output is 0. The exception is in_ready, which is 1 once rst deasserts. Reset mid-field discards the field with no partial beats.
- Latency: a field accepted at edge T presents beat 0 at T+1. Beat 1 appears the cycle after beat 0 handshakes.
- enc_error is asserted exactly one cycle, at T+1.
- Throughput: one field per cycle for n ≤ 8 under continuous out_ready; two cycles per field for n > 8.
- Output holds: out_data, out_keep, out_complete and the tags are stable while out_valid && !out_ready, with no glitching.

## Structure
- Package fast_pkg holds:
  - the datatype enum (INT, UINT, DECI, ASCII),
  - the stop-bit constant 8'h80,
  - the encoder state enum,
  - a function packing the error word.
- Sub-module fast_stopbit_sizer: combinational. Takes the 70-bit extended word and signedness, and returns n plus the 10 pre-formatted bytes.
- The top level holds the FSM and the output registers.

## Test plan
- uint 0, 127, 128 → 0x80; 0xFF; 0x01 0x80. Each has out_keep=0x01/0x01/0x03 and out_complete=1.
- int -1, 64, -65 → 0xFF; 0x00 0xC0; 0x7F 0xBF.
- uint 0xFFFF_FFFF_FFFF_FFFF:
  - beat 0 = 0x01 followed by seven 0x7F, keep 0xFF, complete 0.
  - beat 1 = 0x7F 0xFF, keep 0x03, complete 1.
- Nullable uint 0 → 0x81. Nullable NULL → 0x80. ASCII "AB" → 0x41 0xC2. ASCII len 0 → 0x80.
- Errors: in_type=2, and ASCII len 9 → no out_valid, enc_error = {1, msg_id, field_num} for one cycle, in_ready stays 1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles; beat 0 stays stable and in_ready=0.
  - Back-to-back 1-byte fields with out_ready=1 → one beat per cycle.
  - Assert rst during BEAT1 → out_valid=0 next cycle and no beat-1 emission.
